// File: rtl/multdiv_sequencer_if.sv
// Bundle of the issue, multdiv-unit and writeback signals around the multdiv sequencer.
// The master modport is the pipeline/unit side; the slave modport is the sequencer.
interface multdiv_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              issue_valid;
  logic              issue_is_div;
  logic [DATA_W-1:0] issue_a;
  logic [DATA_W-1:0] issue_b;
  logic [REG_W-1:0]  issue_rd;
  logic              flush;
  logic              md_ready;
  logic              md_exception;
  logic [DATA_W-1:0] md_result;
  logic              md_ctrl_mult;
  logic              md_ctrl_div;
  logic [DATA_W-1:0] md_a;
  logic [DATA_W-1:0] md_b;
  logic              stall;
  logic              wb_valid;
  logic [REG_W-1:0]  wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              busy;

  modport master (
    output issue_valid, issue_is_div, issue_a, issue_b, issue_rd, flush,
           md_ready, md_exception, md_result,
    input  md_ctrl_mult, md_ctrl_div, md_a, md_b, stall,
           wb_valid, wb_rd, wb_data, busy
  );

  modport slave (
    input  issue_valid, issue_is_div, issue_a, issue_b, issue_rd, flush,
           md_ready, md_exception, md_result,
    output md_ctrl_mult, md_ctrl_div, md_a, md_b, stall,
           wb_valid, wb_rd, wb_data, busy
  );
endinterface

// File: rtl/multdiv_sequencer.sv
// Pipeline-side controller for the shared multdiv unit: accept, start pulse, stall, writeback.
// Optional MULTDIV_DIV0_SHORTCUT_EN: div by zero skips the unit and goes straight to DONE.
module multdiv_sequencer #(
  parameter int DATA_W       = 32,
  parameter int REG_W        = 5,
  parameter int TIMEOUT      = 40,
  parameter int STATUS_REG   = 30,
  parameter int MUL_EXC_CODE = 4,
  parameter int DIV_EXC_CODE = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  multdiv_sequencer_if.slave    bus
);

  localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_e;

  state_e            state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic              is_div_q, is_div_d;
  logic [REG_W-1:0]  wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              wb_en_q, wb_en_d;
  logic              take_exc;
  logic              accept;

  function automatic logic [DATA_W-1:0] exc_code(input logic div_op);
    return div_op ? DATA_W'(DIV_EXC_CODE) : DATA_W'(MUL_EXC_CODE);
  endfunction

  assign accept = bus.issue_valid && !bus.flush;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    a_d       = a_q;
    b_d       = b_q;
    rd_d      = rd_q;
    is_div_d  = is_div_q;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    wb_en_d   = wb_en_q;
    take_exc  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d      = bus.issue_a;
          b_d      = bus.issue_b;
          rd_d     = bus.issue_rd;
          is_div_d = bus.issue_is_div;
          state_d  = START;
`ifdef MULTDIV_DIV0_SHORTCUT_EN
          if (bus.issue_is_div && (bus.issue_b == '0)) begin
            state_d   = DONE;
            wb_rd_d   = REG_W'(STATUS_REG);
            wb_data_d = exc_code(1'b1);
            wb_en_d   = 1'b1;
          end
`endif
        end
      end
      START: begin
        // Any md_ready seen here belongs to the previous op.
        timer_d = '0;
        state_d = BUSY;
      end
      BUSY: begin
        timer_d = (timer_q == TMR_MAX) ? timer_q : timer_q + TMR_W'(1);
        if (bus.md_ready || (timer_q == TMR_MAX)) begin
          // A real ready wins over a timeout landing in the same cycle.
          take_exc = bus.md_ready ? bus.md_exception : 1'b1;
          state_d  = DONE;
          if (take_exc) begin
            wb_rd_d   = REG_W'(STATUS_REG);
            wb_data_d = exc_code(is_div_q);
            wb_en_d   = 1'b1;
          end else begin
            wb_rd_d   = rd_q;
            wb_data_d = bus.md_result;
            wb_en_d   = (rd_q != '0);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A squash discards the op and leaves the writeback registers untouched.
    if (bus.flush) begin
      state_d   = IDLE;
      wb_rd_d   = wb_rd_q;
      wb_data_d = wb_data_q;
      wb_en_d   = wb_en_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rd_q      <= '0;
      is_div_q  <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      wb_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rd_q      <= rd_d;
      is_div_q  <= is_div_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      wb_en_q   <= wb_en_d;
    end
  end

  assign bus.md_ctrl_mult = (state_q == START) && !is_div_q;
  assign bus.md_ctrl_div  = (state_q == START) && is_div_q;
  assign bus.md_a         = a_q;
  assign bus.md_b         = b_q;
  assign bus.stall        = ((state_q == IDLE) && bus.issue_valid) ||
                            (state_q == START) || (state_q == BUSY);
  assign bus.wb_valid     = (state_q == DONE) && wb_en_q && !bus.flush;
  assign bus.wb_rd        = wb_rd_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer: vector table of complete ops plus flush/reset/div0 sequences.
module tb_multdiv_sequencer;

  localparam int DATA_W  = 32;
  localparam int REG_W   = 5;
  localparam int TIMEOUT = 40;
  localparam int NVEC    = 8;

  logic clock;
  logic reset;

  multdiv_sequencer_if #(.DATA_W(DATA_W), .REG_W(REG_W)) bus ();

  multdiv_sequencer #(
    .DATA_W(DATA_W), .REG_W(REG_W), .TIMEOUT(TIMEOUT),
    .STATUS_REG(30), .MUL_EXC_CODE(4), .DIV_EXC_CODE(5)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        is_div;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    int          delay;
    logic        exc;
    logic [31:0] res;
    logic        exp_v;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [NVEC];

  int n_cmp  = 0;
  int n_fail = 0;
  int mult_cnt = 0;
  int div_cnt  = 0;
  int both_cnt = 0;
  int wbv_cnt  = 0;
  logic [4:0]  last_rd;
  logic [31:0] last_data;

  always @(negedge clock) begin
    if (bus.md_ctrl_mult) mult_cnt <= mult_cnt + 1;
    if (bus.md_ctrl_div)  div_cnt  <= div_cnt + 1;
    if (bus.md_ctrl_mult && bus.md_ctrl_div) both_cnt <= both_cnt + 1;
    if (bus.wb_valid)     wbv_cnt  <= wbv_cnt + 1;
  end

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk32(name, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk1 ({tag, "/mult"},  bus.md_ctrl_mult, 1'b0);
    chk1 ({tag, "/div"},   bus.md_ctrl_div,  1'b0);
    chk32({tag, "/md_a"},  bus.md_a,         32'h0);
    chk32({tag, "/md_b"},  bus.md_b,         32'h0);
    chk1 ({tag, "/stall"}, bus.stall,        1'b0);
    chk1 ({tag, "/wbv"},   bus.wb_valid,     1'b0);
    chk32({tag, "/wb_rd"}, 32'(bus.wb_rd),   32'h0);
    chk32({tag, "/wb_data"}, bus.wb_data,    32'h0);
    chk1 ({tag, "/busy"},  bus.busy,         1'b0);
  endtask

  // Entered at posedge+1 with the sequencer idle; leaves at posedge+2 of the idle cycle after DONE.
  task automatic run_op(input vec_t v);
    int m0, d0, w0, nb;
    m0 = mult_cnt; d0 = div_cnt; w0 = wbv_cnt;
    bus.issue_valid  = 1'b1;
    bus.issue_is_div = v.is_div;
    bus.issue_a      = v.a;
    bus.issue_b      = v.b;
    bus.issue_rd     = v.rd;
    #1 chk1({v.name, "/acc_stall"}, bus.stall, 1'b1);
    @(posedge clock); #1;
    bus.md_ready     = 1'b1;
    bus.md_exception = 1'b1;
    bus.md_result    = 32'hDEAD_BEEF;
    #1;
    chk1 ({v.name, "/start_mult"}, bus.md_ctrl_mult, !v.is_div);
    chk1 ({v.name, "/start_div"},  bus.md_ctrl_div,  v.is_div);
    chk32({v.name, "/md_a"},       bus.md_a,         v.a);
    chk32({v.name, "/md_b"},       bus.md_b,         v.b);
    chk1 ({v.name, "/start_stall"}, bus.stall,       1'b1);
    @(posedge clock); #1;
    bus.md_ready     = 1'b0;
    bus.md_exception = 1'b0;
    nb = (v.delay == 0) ? TIMEOUT : v.delay;
    for (int k = 1; k <= nb; k++) begin
      if (k == v.delay) begin
        bus.md_ready     = 1'b1;
        bus.md_result    = v.res;
        bus.md_exception = v.exc;
      end
      #1;
      chk1({v.name, "/busy_stall"}, bus.stall,    1'b1);
      chk1({v.name, "/busy_wbv"},   bus.wb_valid, 1'b0);
      @(posedge clock); #1;
      bus.md_ready     = 1'b0;
      bus.md_exception = 1'b0;
    end
    #1;
    chk1({v.name, "/done_wbv"},   bus.wb_valid, v.exp_v);
    if (v.exp_v) begin
      chk32({v.name, "/done_rd"},   32'(bus.wb_rd), 32'(v.exp_rd));
      chk32({v.name, "/done_data"}, bus.wb_data,    v.exp_data);
      last_rd   = v.exp_rd;
      last_data = v.exp_data;
    end
    chk1({v.name, "/done_stall"}, bus.stall, 1'b0);
    chk1({v.name, "/done_busy"},  bus.busy,  1'b1);
    @(posedge clock); #1;
    bus.issue_valid = 1'b0;
    #1;
    chk1({v.name, "/idle_busy"}, bus.busy,     1'b0);
    chk1({v.name, "/idle_wbv"},  bus.wb_valid, 1'b0);
    if (v.exp_v) chk32({v.name, "/hold_data"}, bus.wb_data, v.exp_data);
    chk32({v.name, "/mult_pulses"}, 32'(mult_cnt - m0), v.is_div ? 32'd0 : 32'd1);
    chk32({v.name, "/div_pulses"},  32'(div_cnt - d0),  v.is_div ? 32'd1 : 32'd0);
    chk32({v.name, "/wb_pulses"},   32'(wbv_cnt - w0),  v.exp_v ? 32'd1 : 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    vecs[0] = '{"mul7x6",   1'b0, 32'd7,          32'd6, 5'd3,  33, 1'b0, 32'd42,         1'b1, 5'd3,  32'd42};
    vecs[1] = '{"div100_7", 1'b1, 32'd100,        32'd7, 5'd5,  10, 1'b0, 32'd14,         1'b1, 5'd5,  32'd14};
    vecs[2] = '{"mul_exc",  1'b0, 32'h7FFF_FFFF,  32'd2, 5'd8,  5,  1'b1, 32'h1234_5678,  1'b1, 5'd30, 32'd4};
    vecs[3] = '{"div_exc",  1'b1, 32'd5,          32'd3, 5'd9,  1,  1'b1, 32'h0000_0001,  1'b1, 5'd30, 32'd5};
    vecs[4] = '{"mul_tmo",  1'b0, 32'd3,          32'd4, 5'd9,  0,  1'b0, 32'd0,          1'b1, 5'd30, 32'd4};
    vecs[5] = '{"mul_rd0",  1'b0, 32'd3,          32'd3, 5'd0,  2,  1'b0, 32'd9,          1'b0, 5'd0,  32'd0};
    vecs[6] = '{"div_rd0x", 1'b1, 32'd8,          32'd2, 5'd0,  4,  1'b1, 32'd4,          1'b1, 5'd30, 32'd5};
    vecs[7] = '{"mul_big",  1'b0, 32'hFFFF_FFFF,  32'd2, 5'd31, 1,  1'b0, 32'hFFFF_FFFE,  1'b1, 5'd31, 32'hFFFF_FFFE};

    reset            = 1'b1;
    bus.issue_valid  = 1'b0;
    bus.issue_is_div = 1'b0;
    bus.issue_a      = '0;
    bus.issue_b      = '0;
    bus.issue_rd     = '0;
    bus.flush        = 1'b0;
    bus.md_ready     = 1'b0;
    bus.md_exception = 1'b0;
    bus.md_result    = '0;
    last_rd          = '0;
    last_data        = '0;

    repeat (2) @(posedge clock);
    #1 chk_zero_outputs("reset");
    reset = 1'b0;
    @(posedge clock); #1;

    for (int i = 0; i < NVEC; i++) run_op(vecs[i]);

    // Flush in the 10th BUSY cycle: no writeback, back to IDLE, writeback regs keep prior op.
    w0 = wbv_cnt;
    bus.issue_valid  = 1'b1;
    bus.issue_is_div = 1'b0;
    bus.issue_a      = 32'd11;
    bus.issue_b      = 32'd13;
    bus.issue_rd     = 5'd4;
    @(posedge clock); #1;
    @(posedge clock); #1;
    for (int k = 1; k < 10; k++) @(posedge clock);
    #1;
    bus.flush = 1'b1;
    #1 chk1("flush/busy10_stall", bus.stall, 1'b1);
    @(posedge clock); #1;
    bus.flush       = 1'b0;
    bus.issue_valid = 1'b0;
    #1;
    chk1 ("flush/idle_busy", bus.busy,     1'b0);
    chk1 ("flush/idle_wbv",  bus.wb_valid, 1'b0);
    chk32("flush/hold_rd",   32'(bus.wb_rd), 32'(last_rd));
    chk32("flush/hold_data", bus.wb_data,  last_data);
    @(posedge clock); #1;
    chk1 ("flush/still_idle", bus.busy, 1'b0);
    chk32("flush/no_wb", 32'(wbv_cnt - w0), 32'd0);

    // Flush together with issue in IDLE: op must not be accepted.
    bus.issue_valid = 1'b1;
    bus.flush       = 1'b1;
    bus.issue_a     = 32'd77;
    @(posedge clock); #1;
    bus.issue_valid = 1'b0;
    bus.flush       = 1'b0;
    #1;
    chk1 ("flush_issue/busy", bus.busy, 1'b0);
    chk32("flush_issue/md_a", bus.md_a, 32'd11);
    @(posedge clock); #1;

    // Asynchronous reset in the middle of BUSY, then a clean op.
    bus.issue_valid  = 1'b1;
    bus.issue_is_div = 1'b1;
    bus.issue_a      = 32'h1234;
    bus.issue_b      = 32'h55;
    bus.issue_rd     = 5'd6;
    @(posedge clock); #1;
    repeat (6) @(posedge clock);
    #1;
    chk1("rst_mid/busy_before", bus.busy, 1'b1);
    bus.issue_valid = 1'b0;
    reset = 1'b1;
    #1 chk_zero_outputs("rst_mid");
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    run_op(vecs[0]);

    // Div by zero.
`ifdef MULTDIV_DIV0_SHORTCUT_EN
    begin
      int d0;
      d0 = div_cnt; w0 = wbv_cnt;
      bus.issue_valid  = 1'b1;
      bus.issue_is_div = 1'b1;
      bus.issue_a      = 32'd9;
      bus.issue_b      = 32'd0;
      bus.issue_rd     = 5'd7;
      #1 chk1("div0/acc_stall", bus.stall, 1'b1);
      @(posedge clock); #1;
      #1;
      chk1 ("div0/wbv",   bus.wb_valid, 1'b1);
      chk32("div0/rd",    32'(bus.wb_rd), 32'd30);
      chk32("div0/data",  bus.wb_data,  32'd5);
      chk1 ("div0/stall", bus.stall,    1'b0);
      @(posedge clock); #1;
      bus.issue_valid = 1'b0;
      #1;
      chk1 ("div0/idle", bus.busy, 1'b0);
      chk32("div0/no_div_pulse", 32'(div_cnt - d0), 32'd0);
      chk32("div0/one_wb",       32'(wbv_cnt - w0), 32'd1);
    end
`else
    begin
      vec_t v0;
      v0 = '{"div0_norm", 1'b1, 32'd9, 32'd0, 5'd7, 3, 1'b1, 32'd0, 1'b1, 5'd30, 32'd5};
      run_op(v0);
    end
`endif

    @(posedge clock); #1;
    chk32("never_both_pulses", 32'(both_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
